// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter.
//   RstEnable / Stop / NoStop / ZeroWord : common pipeline-level constants
//   ST_*                                 : arbiter FSM state encodings
`timescale 1ns/1ps
package mem_bus_arbiter_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_BUS_IF  = 2'd1;
    localparam logic [1:0]  ST_BUS_MEM = 2'd2;
    localparam logic [1:0]  ST_DONE    = 2'd3;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus-cycle watchdog: counts bus cycles that see neither ack nor err.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : hold count at zero (asserted whenever no bus cycle is open)
//   enable    : count this cycle
//   expired   : count has reached TIMEOUT-1 (never asserted when TIMEOUT = 0)
`timescale 1ns/1ps
module bus_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            logic [CW-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (rst == RstEnable || clear) begin
                    count_reg <= '0;
                end else if (enable) begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            // Expiry is seen in the TIMEOUT-th bus cycle, so the cycle is
            // terminated after exactly TIMEOUT cycles with strobe high.
            assign expired = (count_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Wishbone-style memory port between instruction fetch (IF,
// read-only) and load/store (MEM). MEM has priority. Each access runs
// IDLE -> BUS_x -> DONE -> IDLE, so back-to-back grants are impossible.
//   flush_i                       : pipeline flush, discards an in-flight fetch
//   if_req_i/if_addr_i            : fetch request, held until if_done_o
//   if_rdata_o/if_done_o/if_err_o : fetch result (registered, 1-cycle pulse)
//   mem_req_i/mem_we_i/mem_sel_i/mem_addr_i/mem_wdata_i : load/store request
//   mem_rdata_o/mem_done_o/mem_err_o                    : load/store result
//   stallreq_from_if/mem          : requester waiting for its completion
//   bus_*                         : external bus master port (registered)
`timescale 1ns/1ps
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_done_o,
    output logic            if_err_o,
    output logic            stallreq_from_if,
    input  logic            mem_req_i,
    input  logic            mem_we_i,
    input  logic [DW/8-1:0] mem_sel_i,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [DW-1:0]   mem_wdata_i,
    output logic [DW-1:0]   mem_rdata_o,
    output logic            mem_done_o,
    output logic            mem_err_o,
    output logic            stallreq_from_mem,
    output logic            bus_cyc_o,
    output logic            bus_stb_o,
    output logic            bus_we_o,
    output logic [DW/8-1:0] bus_sel_o,
    output logic [AW-1:0]   bus_adr_o,
    output logic [DW-1:0]   bus_dat_o,
    input  logic [DW-1:0]   bus_dat_i,
    input  logic            bus_ack_i,
    input  logic            bus_err_i
);

    logic [1:0] state_reg;
    logic       discard_reg;
    logic       bus_active;
    logic       timeout;
    logic       bus_end;
    logic       bus_fail;
    logic       if_grant;
    logic       if_discard;

    assign bus_active = (state_reg == ST_BUS_IF) || (state_reg == ST_BUS_MEM);
    assign bus_end    = bus_active && (bus_ack_i || bus_err_i || timeout);
    // ack together with err is treated as an error
    assign bus_fail   = bus_err_i || timeout;
    // A fetch presented in a flush cycle belongs to the squashed path
    assign if_grant   = if_req_i && !flush_i && !mem_req_i;
    // A flush landing on the completing edge squashes that fetch as well
    assign if_discard = discard_reg || flush_i;

    assign stallreq_from_if  = (if_req_i  && !if_done_o)  ? Stop : NoStop;
    assign stallreq_from_mem = (mem_req_i && !mem_done_o) ? Stop : NoStop;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!bus_active),
        .enable  (bus_active && !bus_ack_i && !bus_err_i),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg   <= ST_IDLE;
            discard_reg <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_adr_o   <= '0;
            bus_dat_o   <= DW'(ZeroWord);
            if_rdata_o  <= DW'(ZeroWord);
            if_done_o   <= 1'b0;
            if_err_o    <= 1'b0;
            mem_rdata_o <= DW'(ZeroWord);
            mem_done_o  <= 1'b0;
            mem_err_o   <= 1'b0;
        end else begin
            // completion flags are single-cycle pulses
            if_done_o  <= 1'b0;
            if_err_o   <= 1'b0;
            mem_done_o <= 1'b0;
            mem_err_o  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        bus_cyc_o <= 1'b1;
                        bus_stb_o <= 1'b1;
                        bus_we_o  <= mem_we_i;
                        bus_sel_o <= mem_sel_i;
                        bus_adr_o <= mem_addr_i;
                        bus_dat_o <= mem_wdata_i;
                        state_reg <= ST_BUS_MEM;
                    end else if (if_grant) begin
                        bus_cyc_o <= 1'b1;
                        bus_stb_o <= 1'b1;
                        bus_we_o  <= 1'b0;
                        bus_sel_o <= '1;
                        bus_adr_o <= if_addr_i;
                        bus_dat_o <= DW'(ZeroWord);
                        state_reg <= ST_BUS_IF;
                    end
                end

                ST_BUS_IF: begin
                    // The bus cycle always runs to completion; a flush only
                    // hides its result from the fetch stage.
                    if (flush_i) begin
                        discard_reg <= 1'b1;
                    end
                    if (bus_end) begin
                        bus_cyc_o <= 1'b0;
                        bus_stb_o <= 1'b0;
                        state_reg <= ST_DONE;
                        if (!if_discard) begin
                            if_done_o <= 1'b1;
                            if_err_o  <= bus_fail;
                            if (!bus_fail) begin
                                if_rdata_o <= bus_dat_i;
                            end
                        end
                    end
                end

                ST_BUS_MEM: begin
                    if (bus_end) begin
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        state_reg  <= ST_DONE;
                        mem_done_o <= 1'b1;
                        mem_err_o  <= bus_fail;
                        if (!bus_fail && !bus_we_o) begin
                            mem_rdata_o <= bus_dat_i;
                        end
                    end
                end

                ST_DONE: begin
                    discard_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_done_o;
    logic          if_err_o;
    logic          stallreq_from_if;
    logic          mem_req_i;
    logic          mem_we_i;
    logic [3:0]    mem_sel_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_done_o;
    logic          mem_err_o;
    logic          stallreq_from_mem;
    logic          bus_cyc_o;
    logic          bus_stb_o;
    logic          bus_we_o;
    logic [3:0]    bus_sel_o;
    logic [AW-1:0] bus_adr_o;
    logic [DW-1:0] bus_dat_o;
    logic [DW-1:0] bus_dat_i;
    logic          bus_ack_i;
    logic          bus_err_i;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .if_req_i          (if_req_i),
        .if_addr_i         (if_addr_i),
        .if_rdata_o        (if_rdata_o),
        .if_done_o         (if_done_o),
        .if_err_o          (if_err_o),
        .stallreq_from_if  (stallreq_from_if),
        .mem_req_i         (mem_req_i),
        .mem_we_i          (mem_we_i),
        .mem_sel_i         (mem_sel_i),
        .mem_addr_i        (mem_addr_i),
        .mem_wdata_i       (mem_wdata_i),
        .mem_rdata_o       (mem_rdata_o),
        .mem_done_o        (mem_done_o),
        .mem_err_o         (mem_err_o),
        .stallreq_from_mem (stallreq_from_mem),
        .bus_cyc_o         (bus_cyc_o),
        .bus_stb_o         (bus_stb_o),
        .bus_we_o          (bus_we_o),
        .bus_sel_o         (bus_sel_o),
        .bus_adr_o         (bus_adr_o),
        .bus_dat_o         (bus_dat_o),
        .bus_dat_i         (bus_dat_i),
        .bus_ack_i         (bus_ack_i),
        .bus_err_i         (bus_err_i)
    );

    typedef struct {
        bit          is_mem;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_exp_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
        logic        err;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // slave behaviour knobs and reference model state
    int          slave_waits = 0;
    bit          slave_err   = 1'b0;
    bit          slave_noack = 1'b0;
    bit          late_ack    = 1'b0;
    logic [31:0] rd_base     = 32'h2402_0001;
    logic [31:0] last_if     = 32'h0;
    logic [31:0] last_mem    = 32'h0;
    int          stall_if_cnt;
    int          stall_mem_cnt;
    int          cyc_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_bus(input bit is_mem, input logic [31:0] adr, input logic we,
                            input logic [3:0] sel, input logic [31:0] dat);
        bus_exp_t e;
        e.is_mem = is_mem; e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
        bus_q.push_back(e);
    endtask

    task automatic push_done(input bit is_mem, input logic [31:0] rdata, input logic err);
        done_exp_t e;
        e.is_mem = is_mem; e.rdata = rdata; e.err = err;
        done_q.push_back(e);
    endtask

    // expected IF fetch: bus cycle plus completion; errors keep old rdata
    task automatic exp_if(input logic [31:0] adr, input bit err);
        logic [31:0] rd;
        push_bus(1'b0, adr, 1'b0, 4'hF, 32'h0);
        rd = err ? last_if : rd_base + adr;
        push_done(1'b0, rd, err);
        last_if = rd;
    endtask

    // expected MEM access: stores and errors keep old rdata
    task automatic exp_mem(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] wdata, input bit err);
        logic [31:0] rd;
        push_bus(1'b1, adr, we, sel, wdata);
        rd = (err || we) ? last_mem : rd_base + adr;
        push_done(1'b1, rd, err);
        last_mem = rd;
    endtask

    // bus slave: ack (or err) after slave_waits wait states
    initial begin : slave
        int wcnt;
        wcnt = 0;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_dat_i = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (bus_cyc_o) wcnt++; else wcnt = 0;
            if (bus_cyc_o && !slave_noack && wcnt > slave_waits) begin
                bus_ack_i = !slave_err;
                bus_err_i = slave_err;
                bus_dat_i = slave_err ? 32'hDEAD_BEEF : rd_base + bus_adr_o;
            end else begin
                bus_ack_i = late_ack;
                bus_err_i = 1'b0;
                bus_dat_i = 32'hBAD0_BAD0;
            end
        end
    end

    // bus monitor: every new cycle must match the next expected grant
    initial begin : bus_mon
        bit       prev_cyc;
        bus_exp_t e;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_cyc_o && !prev_cyc) begin
                check_eq("bus_q_nonempty", 64'(bus_q.size() != 0), 1);
                if (bus_q.size() != 0) begin
                    e = bus_q.pop_front();
                    $display("[%0t] bus %s adr=%h we=%0b sel=%h dat=%h", $time,
                             e.is_mem ? "MEM" : "IF ", bus_adr_o, bus_we_o, bus_sel_o, bus_dat_o);
                    check_eq("bus_adr", bus_adr_o, e.adr);
                    check_eq("bus_we",  bus_we_o,  e.we);
                    check_eq("bus_sel", bus_sel_o, e.sel);
                    check_eq("bus_dat", bus_dat_o, e.dat);
                    check_eq("bus_stb", bus_stb_o, 1);
                end
            end
            prev_cyc = bus_cyc_o;
        end
    end

    // completion monitor: pop the scoreboard on every done pulse
    initial begin : done_mon
        done_exp_t e;
        forever begin
            @(negedge clk);
            if (if_done_o) begin
                check_eq("if_done_expected", 64'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    $display("[%0t] IF  done rdata=%h err=%0b", $time, if_rdata_o, if_err_o);
                    check_eq("done_src_if", 0, e.is_mem);
                    check_eq("if_rdata", if_rdata_o, e.rdata);
                    check_eq("if_err", if_err_o, e.err);
                end
            end
            if (mem_done_o) begin
                check_eq("mem_done_expected", 64'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    $display("[%0t] MEM done rdata=%h err=%0b", $time, mem_rdata_o, mem_err_o);
                    check_eq("done_src_mem", 1, e.is_mem);
                    check_eq("mem_rdata", mem_rdata_o, e.rdata);
                    check_eq("mem_err", mem_err_o, e.err);
                end
            end
        end
    end

    // hold requests until their done pulse; count stall and bus cycles
    task automatic service(input int budget);
        int n;
        n = 0;
        stall_if_cnt  = 0;
        stall_mem_cnt = 0;
        cyc_cnt       = 0;
        while ((if_req_i || mem_req_i) && n < budget) begin
            #1;
            if (stallreq_from_if)  stall_if_cnt++;
            if (stallreq_from_mem) stall_mem_cnt++;
            if (bus_cyc_o)         cyc_cnt++;
            if (if_done_o)  if_req_i  = 1'b0;
            if (mem_done_o) mem_req_i = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq("service_complete", {if_req_i, mem_req_i}, 0);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
    endtask

    task automatic wait_cyc(input int budget);
        int n;
        n = 0;
        while (!bus_cyc_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_cyc", bus_cyc_o, 1);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check_eq({tag, "_bus_q_empty"},  bus_q.size(),  0);
        check_eq({tag, "_done_q_empty"}, done_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst         = 1'b1;
        flush_i     = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;

        // reset state; a request during reset must not start a cycle
        repeat (3) @(negedge clk);
        if_req_i = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_cyc",       bus_cyc_o,   0);
        check_eq("rst_stb",       bus_stb_o,   0);
        check_eq("rst_we",        bus_we_o,    0);
        check_eq("rst_sel",       bus_sel_o,   0);
        check_eq("rst_adr",       bus_adr_o,   0);
        check_eq("rst_dat",       bus_dat_o,   0);
        check_eq("rst_if_done",   if_done_o,   0);
        check_eq("rst_mem_done",  mem_done_o,  0);
        check_eq("rst_if_rdata",  if_rdata_o,  0);
        check_eq("rst_mem_rdata", mem_rdata_o, 0);
        check_eq("rst_stall_if",  stallreq_from_if, 1);
        if_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: IF read, two wait states
        slave_waits = 2;
        exp_if(32'h0, 1'b0);
        if_addr_i = 32'h0;
        if_req_i  = 1'b1;
        service(50);
        check_eq("t1_stall_if_cycles", stall_if_cnt, 4);
        check_eq("t1_cyc_cycles", cyc_cnt, 3);
        drain("t1");

        // 2: simultaneous requests, MEM store wins
        slave_waits = 0;
        exp_mem(1'b1, 4'b0011, 32'h100, 32'h1122_3344, 1'b0);
        exp_if(32'h8, 1'b0);
        mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h100; mem_wdata_i = 32'h1122_3344;
        if_addr_i = 32'h8;
        mem_req_i = 1'b1;
        if_req_i  = 1'b1;
        service(60);
        check_eq("t2_stall_if_cycles", stall_if_cnt, 5);
        check_eq("t2_stall_mem_cycles", stall_mem_cnt, 2);
        drain("t2");

        // 3: good load, then a load that errors keeps the old data
        exp_mem(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
        mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h40; mem_wdata_i = 32'h0;
        mem_req_i = 1'b1;
        service(40);
        slave_err = 1'b1;
        exp_mem(1'b0, 4'hF, 32'h44, 32'h0, 1'b1);
        mem_addr_i = 32'h44;
        mem_req_i  = 1'b1;
        service(40);
        slave_err = 1'b0;
        drain("t3");

        // 4: no response, watchdog terminates the fetch
        slave_noack = 1'b1;
        exp_if(32'h20, 1'b1);
        if_addr_i = 32'h20;
        if_req_i  = 1'b1;
        service(40);
        check_eq("t4_cyc_cycles", cyc_cnt, TMO);
        slave_noack = 1'b0;
        drain("t4");

        // 5: flush during a fetch; only the redirected fetch completes
        slave_waits = 3;
        push_bus(1'b0, 32'h180, 1'b0, 4'hF, 32'h0);
        if_addr_i = 32'h180;
        if_req_i  = 1'b1;
        wait_cyc(10);
        flush_i   = 1'b1;
        if_addr_i = 32'h200;
        @(negedge clk);
        flush_i = 1'b0;
        slave_waits = 0;
        exp_if(32'h200, 1'b0);
        service(60);
        drain("t5");

        // 6: reset during a MEM cycle, then a stray ack
        slave_noack = 1'b1;
        push_bus(1'b1, 32'h300, 1'b1, 4'hF, 32'hA5A5_A5A5);
        mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h300; mem_wdata_i = 32'hA5A5_A5A5;
        mem_req_i = 1'b1;
        wait_cyc(10);
        @(negedge clk);
        rst       = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk);
        check_eq("t6_cyc_after_rst", bus_cyc_o, 0);
        check_eq("t6_stb_after_rst", bus_stb_o, 0);
        check_eq("t6_done_after_rst", mem_done_o, 0);
        rst      = 1'b0;
        last_if  = 32'h0;
        last_mem = 32'h0;
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("t6_late_ack_done", {if_done_o, mem_done_o}, 0);
            check_eq("t6_late_ack_cyc", bus_cyc_o, 0);
        end
        late_ack    = 1'b0;
        slave_noack = 1'b0;
        @(negedge clk);
        exp_if(32'h10, 1'b0);
        if_addr_i = 32'h10;
        if_req_i  = 1'b1;
        service(40);
        check_eq("t6_stall_if_cycles", stall_if_cnt, 2);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
